// File: rtl/lcd_text_driver.sv
// Refreshes an HD44780 16x2 LCD from a 32-character text source by scanning index 0..31.
// Optional LCD_4BIT_EN selects the nibble-wide bus; the default build drives all 8 data lines.
module lcd_text_driver #(
   parameter int POWERUP_CYC = 750000,
   parameter int CMD_CYC     = 2000,
   parameter int CLR_CYC     = 82000,
   parameter int E_HIGH_CYC  = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_in,
   output logic [4:0] index,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [7:0] lcd_data,
   output logic       init_done,
   output logic       frame_done
);
   localparam int MAX_A = (POWERUP_CYC > CLR_CYC) ? POWERUP_CYC : CLR_CYC;
   localparam int MAX_B = (CMD_CYC > E_HIGH_CYC + 4) ? CMD_CYC : E_HIGH_CYC + 4;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W = $clog2(MAX_C + 1);
`ifdef LCD_4BIT_EN
   localparam int NCMD  = 5;
`else
   localparam int NCMD  = 4;
`endif
   localparam int PTR_W = $clog2(NCMD);

   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NCMD - 1);
   localparam logic [CNT_W-1:0] C_PWR     = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] C_CMD     = CNT_W'(CMD_CYC - 1);
   localparam logic [CNT_W-1:0] C_CLR     = CNT_W'(CLR_CYC - 1);
   localparam logic [CNT_W-1:0] C_EEND    = CNT_W'(E_HIGH_CYC + 1);
`ifdef LCD_4BIT_EN
   localparam logic [CNT_W-1:0] C_IDLE_END = CNT_W'(E_HIGH_CYC + 3);
`endif

   typedef enum logic [2:0] {S_PWRUP, S_INIT, S_SETLINE, S_FETCH, S_WRITE, S_WAIT} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [PTR_W-1:0] r_ptr;
   logic [4:0]       r_index;
   logic [7:0]       r_data;
   logic             r_e;
   logic             r_rs;
   logic             r_init_done;
   logic             r_frame_done;
   logic [CNT_W-1:0] w_wait_end;
`ifdef LCD_4BIT_EN
   logic             r_nib;
   logic             w_single;
`endif

   function automatic logic [7:0] init_cmd(input logic [PTR_W-1:0] p);
      logic [7:0] b;
`ifdef LCD_4BIT_EN
      case (int'(p))
         0:       b = 8'h20;
         1:       b = 8'h28;
         2:       b = 8'h0C;
         3:       b = 8'h06;
         default: b = 8'h01;
      endcase
`else
      case (int'(p))
         0:       b = 8'h38;
         1:       b = 8'h0C;
         2:       b = 8'h06;
         default: b = 8'h01;
      endcase
`endif
      return b;
   endfunction

   // Only the final init command (the clear) needs the long settle time.
   assign w_wait_end = (!r_init_done && r_ptr == LAST_PTR) ? C_CLR : C_CMD;

`ifdef LCD_4BIT_EN
   assign w_single = !r_init_done && (r_ptr == '0);
   assign lcd_data = r_nib ? {r_data[3:0], 4'h0} : {r_data[7:4], 4'h0};
`else
   assign lcd_data = r_data;
`endif

   assign index      = r_index;
   assign lcd_e      = r_e;
   assign lcd_rs     = r_rs;
   assign lcd_rw     = 1'b0;
   assign init_done  = r_init_done;
   assign frame_done = r_frame_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_PWRUP;
         r_cnt        <= '0;
         r_ptr        <= '0;
         r_index      <= '0;
         r_data       <= '0;
         r_e          <= 1'b0;
         r_rs         <= 1'b0;
         r_init_done  <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef LCD_4BIT_EN
         r_nib        <= 1'b0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_PWRUP: begin
               if (r_cnt == C_PWR) begin
                  r_cnt   <= '0;
                  r_ptr   <= '0;
                  r_data  <= init_cmd('0);
                  r_state <= S_INIT;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            // Command byte was loaded on entry, so this cycle is the first setup cycle.
            S_INIT, S_SETLINE: begin
               r_cnt   <= CNT_W'(1);
               r_state <= S_WRITE;
            end
            S_FETCH: begin
               if (r_cnt == CNT_W'(1)) begin
                  r_cnt   <= '0;
                  r_data  <= char_in;
                  r_rs    <= 1'b1;
                  r_state <= S_WRITE;
`ifdef LCD_4BIT_EN
                  r_nib   <= 1'b0;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_e <= 1'b1;
               end
               if (r_cnt == C_EEND) begin
                  r_e <= 1'b0;
`ifdef LCD_4BIT_EN
                  if (r_nib || w_single) begin
                     r_cnt   <= '0;
                     r_state <= S_WAIT;
                  end
`else
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
`endif
               end
`ifdef LCD_4BIT_EN
               // Two idle cycles after the high-nibble strobe, then restart setup for the low nibble.
               if (r_cnt == C_IDLE_END) begin
                  r_cnt <= '0;
                  r_nib <= 1'b1;
               end
`endif
            end
            S_WAIT: begin
               if (r_cnt == w_wait_end) begin
                  r_cnt <= '0;
                  if (!r_init_done || (r_rs && (r_index == 5'd15 || r_index == 5'd31))) begin
                     r_rs <= 1'b0;
`ifdef LCD_4BIT_EN
                     r_nib <= 1'b0;
`endif
                     if (!r_init_done) begin
                        if (r_ptr == LAST_PTR) begin
                           r_init_done <= 1'b1;
                           r_index     <= '0;
                           r_data      <= 8'h80;
                           r_state     <= S_SETLINE;
                        end else begin
                           r_ptr   <= r_ptr + 1'b1;
                           r_data  <= init_cmd(r_ptr + 1'b1);
                           r_state <= S_INIT;
                        end
                     end else begin
                        // 15 -> 16 selects line 2; 31 wraps to 0 and closes the frame.
                        r_index      <= r_index + 5'd1;
                        r_data       <= (r_index == 5'd15) ? 8'hC0 : 8'h80;
                        r_frame_done <= (r_index == 5'd31);
                        r_state      <= S_SETLINE;
                     end
                  end else begin
                     if (r_rs) begin
                        r_index <= r_index + 5'd1;
                     end
                     r_state <= S_FETCH;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_PWRUP;
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_text_driver.sv
// Self-checking bench for lcd_text_driver: timeline model of the write schedule compared every cycle,
// plus literal checks of the init sequence, line addresses, frame boundary, and reset abort.
`timescale 1ns/1ps
module tb_lcd_text_driver;
   localparam int PW       = 20;
   localparam int CW       = 5;
   localparam int LW       = 10;
   localparam int EW       = 2;
   localparam int CL       = 2 + EW + CW;
   localparam int LL       = 2 + EW + LW;
   localparam int DL       = 2 + CL;
   localparam int INIT_LEN = 3 * CL + LL;
   localparam int HALF     = CL + 16 * DL;
   localparam int FRAME    = 2 * HALF;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic [7:0] char_in = 8'h00;
   logic [4:0] index;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data;
   logic       init_done;
   logic       frame_done;

   logic [7:0] tab  [32];
   logic [7:0] snap [32];
   logic [8:0] wlog [$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         t     = 0;

   lcd_text_driver #(
      .POWERUP_CYC (PW),
      .CMD_CYC     (CW),
      .CLR_CYC     (LW),
      .E_HIGH_CYC  (EW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .index      (index),
      .lcd_e      (lcd_e),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_data   (lcd_data),
      .init_done  (init_done),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Text source: registers the byte one cycle after index changes.
   always @(posedge clk) char_in <= tab[index];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input int k);
      case (k)
         0:       return 8'h38;
         1:       return 8'h0C;
         2:       return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   // Returns the character index whose first fetch cycle is cycle tt, else -1.
   function automatic int fetch_start(input int tt);
      int v, q;
      if (tt < PW + INIT_LEN) return -1;
      v = (tt - PW - INIT_LEN) % FRAME;
      q = v % HALF;
      if (q < CL || ((q - CL) % DL) != 0) return -1;
      return 16 * (v / HALF) + (q - CL) / DL;
   endfunction

   // Expected {index, e, rs, rw, data, init_done, frame_done} after tt clocks since reset release.
   function automatic logic [17:0] model(input int tt);
      int u, v, p, h, q, k, o, c, idx;
      logic [4:0] ix;
      logic       ee, rs, idn, fd;
      logic [7:0] d;
      ix = '0; ee = 1'b0; rs = 1'b0; idn = 1'b0; fd = 1'b0; d = '0; c = -1;
      if (tt >= PW) begin
         u = tt - PW;
         if (u < INIT_LEN) begin
            k = (u < 3 * CL) ? u / CL : 3;
            c = u - k * CL;
            d = init_byte(k);
         end else begin
            v   = u - INIT_LEN;
            idn = 1'b1;
            p   = v % FRAME;
            fd  = (v >= FRAME) && (p == 0);
            h   = p / HALF;
            q   = p % HALF;
            if (q < CL) begin
               ix = 5'(16 * h);
               d  = (h != 0) ? 8'hC0 : 8'h80;
               c  = q;
            end else begin
               k   = (q - CL) / DL;
               o   = (q - CL) % DL;
               idx = 16 * h + k;
               ix  = 5'(idx);
               if (o >= 2) begin
                  rs = 1'b1;
                  d  = snap[idx];
                  c  = o - 2;
               end else if (k == 0) begin
                  d = (h != 0) ? 8'hC0 : 8'h80;
               end else begin
                  rs = 1'b1;
                  d  = snap[idx - 1];
               end
            end
         end
         ee = (c >= 2) && (c < 2 + EW);
      end
      return {ix, ee, rs, 1'b0, d, idn, fd};
   endfunction

   initial begin : compare
      logic        prev_e;
      logic [17:0] exp_v;
      logic [17:0] act_v;
      int          fi;
      prev_e = 1'b0;
      forever begin
         @(posedge clk);
         if (rst) t++;
         else t = 0;
         @(negedge clk);
         if (rst) begin
            fi = fetch_start(t);
            if (fi >= 0) snap[fi] = tab[fi];
            exp_v = model(t);
         end else begin
            exp_v = '0;
         end
         act_v = {index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done};
         chk($sformatf("cycle t=%0d", t), 32'(act_v), 32'(exp_v));
         if (lcd_e && !prev_e) wlog.push_back({lcd_rs, lcd_data});
         prev_e = lcd_e;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic tick_rand(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         if ($urandom_range(0, 7) == 0) tab[$urandom_range(0, 31)] = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic wait_log(input int need, input string name);
      int n;
      n = 0;
      while (wlog.size() < need && n < 2000) begin
         tick(1);
         n++;
      end
      if (wlog.size() < need) chk(name, 32'(wlog.size()), 32'(need));
   endtask

   task automatic wait_frame(input string name);
      int n;
      n = 0;
      while (!frame_done && n < 2000) begin
         tick(1);
         n++;
      end
      chk(name, 32'(frame_done), 32'd1);
   endtask

   initial begin : stim
      int         n;
      int         s;
      int         fs;
      int         clears;
      logic [7:0] newv;
      for (int i = 0; i < 32; i++) tab[i] = 8'h41 + 8'(i);
      #1 rst = 1'b0;
      tick(3);
      chk("reset_outputs", 32'({index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done}), 32'd0);
      rst = 1'b1;
      wlog.delete();

      n = 0;
      while (!lcd_e && n < 200) begin
         tick(1);
         n++;
      end
      chk("first_e_cycle", 32'(n), 32'd22);
      while (!init_done && n < 200) begin
         tick(1);
         n++;
      end
      chk("init_done_cycle", 32'(n), 32'd61);

      wait_log(39, "log_timeout_a");
      if (wlog.size() >= 39) begin
         chk("w0_fnset",   32'(wlog[0]),  32'h038);
         chk("w1_dispon",  32'(wlog[1]),  32'h00C);
         chk("w2_entry",   32'(wlog[2]),  32'h006);
         chk("w3_clear",   32'(wlog[3]),  32'h001);
         chk("w4_line1",   32'(wlog[4]),  32'h080);
         chk("w5_idx0",    32'(wlog[5]),  32'h141);
         chk("w20_idx15",  32'(wlog[20]), 32'h150);
         chk("w21_line2",  32'(wlog[21]), 32'h0C0);
         chk("w22_idx16",  32'(wlog[22]), 32'h151);
         chk("w37_idx31",  32'(wlog[37]), 32'h160);
         chk("w38_wrap",   32'(wlog[38]), 32'h080);
      end

      wait_frame("fd_timeout");
      chk("fd_index", 32'(index), 32'd0);
      tick(1);
      chk("fd_width", 32'(frame_done), 32'd0);

      n = 0;
      while (index != 5'd6 && n < 2000) begin
         tick(1);
         n++;
      end
      chk("reach_idx6", 32'(index), 32'd6);
      s = wlog.size();
      if (s >= 1) chk("idx5_old", 32'(wlog[s - 1]), 32'h146);
      newv   = tab[5] ^ 8'($urandom_range(1, 255));
      tab[5] = newv;
      wait_frame("fd_timeout_b");
      fs = wlog.size();
      wait_log(fs + 7, "log_timeout_b");
      if (wlog.size() >= fs + 7) begin
         chk("next_frame_line1", 32'(wlog[fs]), 32'h080);
         chk("idx5_new", 32'(wlog[fs + 6]), 32'({1'b1, newv}));
      end
      clears = 0;
      for (int i = 4; i < wlog.size(); i++) if (wlog[i] == 9'h001) clears++;
      chk("no_refresh_clear", 32'(clears), 32'd0);

      for (int r = 0; r < 6; r++) begin
         tick_rand($urandom_range(50, 600));
         if (r % 2 == 0) begin
            n = 0;
            while (!(index == 5'd9 && lcd_e && lcd_rs) && n < 2000) begin
               tick_rand(1);
               n++;
            end
            chk("mid_write_found", 32'(index == 5'd9 && lcd_e && lcd_rs), 32'd1);
            rst = 1'b0;
            #1;
            chk("abort_e_low", 32'(lcd_e), 32'd0);
         end else begin
            rst = 1'b0;
         end
         tick($urandom_range(1, 4));
         rst = 1'b1;
         wlog.delete();
         tick(1);
         chk("restart_index", 32'(index), 32'd0);
         n = 1;
         while (!lcd_e && n < 200) begin
            tick_rand(1);
            n++;
         end
         chk("restart_first_e", 32'(n), 32'd22);
         wait_log(5, "log_timeout_c");
         if (wlog.size() >= 5) begin
            chk("restart_fnset", 32'(wlog[0]), 32'h038);
            chk("restart_line1", 32'(wlog[4]), 32'h080);
         end
      end

      tick_rand(1500);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/lcd_text_driver.md
Name: lcd_text_driver

Overview:
- Reader/display end of the 32-character text interface driven by the mode screens (watch, set, etc.).
- Scans index 0..31 continuously and samples the ASCII byte the active mode block returns for each index.
- Writes each byte to an HD44780-compatible 16x2 character LCD using timed write cycles. Indices 0..15 go to line 1; indices 16..31 go to line 2.
- Sits between the mode mux and the board LCD pins.

Parameters:
- POWERUP_CYC, 750000, idle cycles after reset before the first command (15 ms at 50 MHz).
- CMD_CYC, 2000, post-write wait for a normal command or data write (40 us).
- CLR_CYC, 82000, post-write wait after the clear command 0x01 (1.64 ms).
- E_HIGH_CYC, 12, number of cycles lcd_e is held high per write.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- char_in  in  8  ASCII byte from the active mode block for the current index. The source registers it one cycle after index changes.
- index  out  5  character position requested, 0..31.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  0 = command, 1 = data.
- lcd_rw  out  1  tied 0 (write only).
- lcd_data  out  8  LCD data bus.
- init_done  out  1  high once the init sequence has completed. Stays high until reset.
- frame_done  out  1  one-cycle pulse after the index-31 write wait completes.

Behaviour:
- Reset (async, rst=0) clears all outputs:
  - index=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, init_done=0, frame_done=0.
  - FSM goes to PWRUP and all counters go to 0.
  - Reset asserted mid-write aborts immediately, dropping lcd_e in the same instant. It restarts from PWRUP with the full power-up wait.
- States: PWRUP, INIT, SETLINE, FETCH, WRITE, WAIT.
- PWRUP: count POWERUP_CYC cycles, then go to INIT with command pointer 0.
- INIT: issues, in order, 8'h38 (function set), 8'h0C (display on, cursor off), 8'h06 (entry increment), 8'h01 (clear). Each is a command write (rs=0) through WRITE/WAIT.
  - The wait after 8'h01 is CLR_CYC; the others use CMD_CYC.
  - After the clear completes, set init_done=1, set index=0, and go to SETLINE.
- SETLINE: command write of the DDRAM address. Index 0 uses 8'h80; index 16 uses 8'hC0. After its CMD_CYC wait, go to FETCH.
- FETCH: index is already stable. Wait exactly 2 cycles (source register latency), latch char_in into lcd_data with rs=1, then go to WRITE.
- WRITE, per write:
  - Cycles 0-1: rs and data stable with e=0 (setup).
  - Next E_HIGH_CYC cycles: e=1.
  - Then e=0 and go to WAIT.
  - lcd_data and rs hold their value until the next write's setup.
- WAIT: count CMD_CYC (or CLR_CYC), then advance:
  - After a data write at index 15: index becomes 16, go to SETLINE.
  - After a data write at index 31: index wraps to 0, pulse frame_done for 1 cycle, go to SETLINE.
  - Otherwise: index+1, go to FETCH.
- index changes only on the WAIT-exit cycle. It is never changed during FETCH or WRITE.
- The clear command is issued only during INIT. Refresh is by overwrite only, so there is no flicker.
- Changes to char_in outside the FETCH sample cycle are ignored. Blinking fields appear on the next frame.
- Frame period = 34 writes × (2 + E_HIGH_CYC + CMD_CYC) + 32 × 2 fetch cycles.
- All counters are sized from their parameters with $clog2. The wait counter must not overflow at CLR_CYC.

Optional Feature:
- LCD_4BIT_EN: 4-bit bus mode.
- When defined:
  - Only lcd_data[7:4] is meaningful; lcd_data[3:0] is driven 0.
  - Each byte is sent as the high nibble, then the low nibble. Each nibble gets its own setup+E pulse, with 2 idle cycles between nibbles.
  - CMD_CYC/CLR_CYC waits apply only after the second nibble.
  - INIT is prefixed by a single-nibble write of 4'h2, followed by a CMD_CYC wait.
  - Function set becomes 8'h28 instead of 8'h38.
- When undefined: the 8-bit behaviour above applies, and no nibble logic is synthesized.

Test Plan (POWERUP_CYC=20, CMD_CYC=5, CLR_CYC=10, E_HIGH_CYC=2):
- Release reset -> no lcd_e edge for 20 cycles. Then four rs=0 writes of 38,0C,06,01 with gaps of 5,5,5,10 cycles. init_done rises after the clear wait.
- char_in model returns 8'h41+index (one-cycle registered) -> data writes are 41..50, then C0 command, then 51..60. lcd_rs=1 only on data writes.
- After the index-31 wait -> frame_done high exactly 1 cycle, index=0, next write is command 8'h80.
- Change char_in model mid-frame at index 5 -> new value appears at index 5 only in the next frame; no clear command is issued.
- Assert rst while lcd_e=1 during data write at index 9 -> lcd_e=0 immediately. After release, the full 20-cycle power-up and init repeat, and index=0.
- With LCD_4BIT_EN, write 8'h41 -> lcd_data[7:4]=4 pulse, then 1 pulse, with lcd_data[3:0]=0 throughout. Init starts with nibble 2, then 28.
